timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_pkg.sv | 42 ++++
 rtl/timer_counter.sv | 134 +++++++++++++
 tb/tb_timer_counter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: shared definitions for the memory-mapped timer/counter.
//   - register offsets within the 16-byte window (addr[3:2])
//   - CTRL field positions and the packed CTRL layout
//   - MODE encodings
//   - FSM state encoding
package timer_counter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned ST_W   = 2;

  // Word offsets selected by addr[3:2]
  localparam logic [OFF_W-1:0] OFF_CTRL   = 2'b00;
  localparam logic [OFF_W-1:0] OFF_PRESET = 2'b01;
  localparam logic [OFF_W-1:0] OFF_COUNT  = 2'b10;
  localparam logic [OFF_W-1:0] OFF_RSVD   = 2'b11;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // MODE encodings; 2'b10/2'b11 fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // FSM state encoding
  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_LOAD = 2'b01;
  localparam logic [ST_W-1:0] ST_CNT  = 2'b10;
  localparam logic [ST_W-1:0] ST_INT  = 2'b11;

  // CTRL register layout, MSB first: {IM, MODE[1:0], EN}
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_counter.sv
// timer_counter: 32-bit down-counting timer with a 16-byte register window.
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous active-high reset
//   addr   - CPU byte address; window hit when addr[31:4]==BASE_ADDR[31:4]
//   we     - word write strobe
//   wdata  - write data
//   rdata  - combinational read data selected by addr[3:2]
//   irq    - interrupt request (IRQ_FLAG & CTRL.IM), combinational
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_nxt;
  ctrl_t             ctrl;
  ctrl_t             ctrl_nxt;
  logic [DATA_W-1:0] preset;
  logic [DATA_W-1:0] preset_nxt;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] count_nxt;
  logic              irq_flag;
  logic              irq_flag_nxt;

  logic              win_hit_c;
  logic              wr_ctrl_c;
  logic              wr_preset_c;
  logic [OFF_W-1:0]  off_c;

  // Byte lane bits are irrelevant for word registers
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  // Address decode; COUNT and reserved offsets have no write path
  assign off_c       = addr[3:2];
  assign win_hit_c   = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl_c   = we && win_hit_c && (off_c == OFF_CTRL);
  assign wr_preset_c = we && win_hit_c && (off_c == OFF_PRESET);

  // State and register storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      irq_flag <= irq_flag_nxt;
    end
  end

  // Next-state and register update; bus writes are applied last so they win
  always_comb begin
    state_nxt    = state;
    ctrl_nxt     = ctrl;
    preset_nxt   = preset;
    count_nxt    = count;
    irq_flag_nxt = irq_flag;

    case (state)
      ST_IDLE: begin
        if (ctrl.en) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl.en) begin
          // Pause: COUNT is frozen; re-enable restarts through LOAD
          state_nxt = ST_IDLE;
        end else if (count > DATA_W'(1)) begin
          count_nxt = count - DATA_W'(1);
        end else begin
          // Also covers PRESET=0, so COUNT never wraps
          count_nxt    = '0;
          irq_flag_nxt = 1'b1;
          state_nxt    = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl.mode == MODE_RELOAD) begin
          irq_flag_nxt = 1'b0;
        end else begin
          ctrl_nxt.en = 1'b0;
        end
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (wr_ctrl_c) begin
      ctrl_nxt     = ctrl_t'(wdata[CTRL_W-1:0]);
      irq_flag_nxt = 1'b0;
    end
    if (wr_preset_c) begin
      preset_nxt = wdata;
    end
  end

  // Read mux; address window is not qualified on reads
  always_comb begin
    rdata = '0;
    case (off_c)
      OFF_CTRL:   rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl};
      OFF_PRESET: rdata = preset;
      OFF_COUNT:  rdata = count;
      OFF_RSVD:   rdata = '0;
      default:    rdata = '0;
    endcase
  end

  assign irq = irq_flag & ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed scenarios plus randomized bus traffic, checked
// against a behavioural model of the timer kept in the bench.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int unsigned n_vec;
  int unsigned n_err;

  // Behavioural model: phase 0=waiting for enable, 1=reload pending,
  // 2=counting down, 3=terminal count reached
  int unsigned m_ctrl;
  int unsigned m_preset;
  int unsigned m_count;
  bit          m_flag;
  int unsigned m_phase;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return m_ctrl & 32'hF;
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_flag && ((m_ctrl >> 3) & 1) == 1;
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = 0;
  endtask

  // One clock edge of the timer's documented behaviour
  task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
    int unsigned nc, np, nn, ph;
    bit nf, en, reload, hit;
    nc = m_ctrl; np = m_preset; nn = m_count; nf = m_flag; ph = m_phase;
    en     = (m_ctrl & 1) == 1;
    reload = ((m_ctrl >> 1) & 3) == 1;
    hit    = w && (a[31:4] == BASE[31:4]);
    if (m_phase == 0) begin
      if (en) ph = 1;
    end else if (m_phase == 1) begin
      nn = m_preset; ph = 2;
    end else if (m_phase == 2) begin
      if (!en) ph = 0;
      else if (m_count > 1) nn = m_count - 1;
      else begin nn = 0; nf = 1; ph = 3; end
    end else begin
      if (reload) nf = 0; else nc = nc & ~32'd1;
      ph = 0;
    end
    if (hit && a[3:2] == 2'd0) begin nc = d & 32'hF; nf = 0; end
    if (hit && a[3:2] == 2'd1) np = d;
    m_ctrl = nc; m_preset = np; m_count = nn; m_flag = nf; m_phase = ph;
  endtask

  // Drive one bus cycle, compare outputs before the edge, then advance the model
  task automatic cycle(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr = a; we = w; wdata = d;
    #2;
    check("rdata", rdata, m_read(a));
    check("irq", {31'b0, irq}, {31'b0, m_irq()});
    @(posedge clk);
    model_step(a, w, d);
    #1;
  endtask

  task automatic wr(input int unsigned off, input logic [31:0] d);
    cycle(BASE + 32'(off * 4), 1'b1, d);
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) cycle(BASE + 32'h8, 1'b0, 32'h0);
  endtask

  task automatic rd_now(input int unsigned off, output logic [31:0] v);
    we = 1'b0; addr = BASE + 32'(off * 4);
    #1;
    v = rdata;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] v;
    bit found;
    n_vec = 0; n_err = 0;
    reset = 1'b1; addr = BASE; we = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int o = 0; o < 4; o++) begin
      addr = BASE + 32'(o * 4); #1;
      check("reset_rdata", rdata, 32'h0);
    end
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    idle(3);
    check("idle_count", dut.rdata, 32'h0);

    // One-shot: irq rises exactly 7 edges after the CTRL write edge
    wr(1, 32'd5);
    wr(0, 32'h0000_0009);
    for (int k = 1; k <= 7; k++) begin
      idle(1);
      check($sformatf("oneshot_edge%0d", k), {31'b0, irq}, (k == 7) ? 32'h1 : 32'h0);
    end
    idle(3);
    check("oneshot_hold_irq", {31'b0, irq}, 32'h1);
    rd_now(0, v); check("oneshot_ctrl", v, 32'h8);
    rd_now(2, v); check("oneshot_count", v, 32'h0);

    // Acknowledge by writing CTRL=0
    wr(0, 32'h0);
    check("ack_irq", {31'b0, irq}, 32'h0);
    idle(4);
    rd_now(2, v); check("ack_count", v, 32'h0);

    // Auto-reload, PRESET=3: first pulse after 5 edges, then every 6
    wr(1, 32'd3);
    wr(0, 32'h0000_000B);
    for (int k = 1; k <= 30; k++) begin
      idle(1);
      check($sformatf("reload_edge%0d", k), {31'b0, irq},
            (k >= 5 && (k - 5) % 6 == 0) ? 32'h1 : 32'h0);
    end

    // Masked one-shot: never raises irq, ends with EN cleared
    wr(0, 32'h0);
    wr(1, 32'd2);
    wr(0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      check("mask_irq", {31'b0, irq}, 32'h0);
    end
    rd_now(2, v); check("mask_count", v, 32'h0);
    rd_now(0, v); check("mask_ctrl", v, 32'h0);

    // Pause at 6 then resume from a fresh reload of 10
    wr(1, 32'd10);
    wr(0, 32'h1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      idle(1);
      if (rdata == 32'd7) found = 1;
    end
    check("pause_reach7", {31'b0, found}, 32'h1);
    wr(0, 32'h0);
    wr(1, 32'd50);
    idle(5);
    rd_now(2, v); check("pause_hold", v, 32'd6);
    wr(1, 32'd10);
    wr(0, 32'h1);
    idle(1);
    rd_now(2, v); check("resume_before_load", v, 32'd6);
    idle(1);
    rd_now(2, v); check("resume_reload", v, 32'd10);

    // Reset mid-count
    wr(0, 32'h0);
    wr(1, 32'd100);
    wr(0, 32'h9);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      idle(1);
      if (rdata == 32'd40) found = 1;
    end
    check("rst_reach40", {31'b0, found}, 32'h1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int o = 0; o < 4; o++) begin
      addr = BASE + 32'(o * 4); #1;
      check("midrst_rdata", rdata, 32'h0);
    end
    check("midrst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(20);
    rd_now(2, v); check("postrst_count", v, 32'h0);
    rd_now(0, v); check("postrst_ctrl", v, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      logic [31:0] a, d;
      r = $urandom_range(0, 999);
      a = BASE | 32'($urandom_range(0, 15));
      if (r < 5) begin
        pulse_reset();
      end else if (r < 300) begin
        if ($urandom_range(0, 4) == 0) a = a ^ (32'h10 << $urandom_range(0, 27));
        if (a[3:2] == 2'd0)
          d = ($urandom() & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15) | ($urandom_range(0, 3) != 0 ? 1 : 0));
        else if ($urandom_range(0, 9) == 0)
          d = $urandom();
        else
          d = 32'($urandom_range(0, 6));
        cycle(a, 1'b1, d);
      end else begin
        cycle(a, 1'b0, $urandom());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
